// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types and widths for the IFU/LSU memory arbiter.
package ysyx_22050612_mem_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_e;

  // Owner encoding doubles as the grant-vector bit index.
  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22050612_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not granted last.
module ysyx_22050612_rr_arb2
  import ysyx_22050612_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] gnt
);

  // Pick the grant from the request pair and the previous winner
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == OwnLsu) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Arbitrates IFU and LSU onto one memory port, one transaction outstanding, with timeout abort.
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  // Counter spans 0..TIMEOUT-1; the abort fires on the cycle holding TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e          state_q, state_d;
  owner_e          owner_q, last_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      gnt;
  logic            busy, resp_hit, tmo_hit, finish;

  ysyx_22050612_rr_arb2 u_rr_arb2 (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign busy     = (state_q == StReq) || (state_q == StWait);
  assign resp_hit = (state_q == StWait) && mem_resp_valid;
  assign tmo_hit  = busy && (cnt_q == CntW'(TIMEOUT - 1));
  assign finish   = resp_hit || tmo_hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response in WAIT takes priority over a coincident timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (ifu_req_ready || lsu_req_ready) state_d = StReq;
      StReq: begin
        if (tmo_hit)            state_d = StIdle;
        else if (mem_req_ready) state_d = StWait;
      end
      StWait: if (finish) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: grants only in IDLE, memory request only in REQ
  always_comb begin
    ifu_req_ready = (state_q == StIdle) && gnt[OwnIfu];
    lsu_req_ready = (state_q == StIdle) && gnt[OwnLsu];
    mem_req_valid = (state_q == StReq);
  end

  // Request latch, timeout counter, response pulses and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q        <= OwnIfu;
      last_q         <= OwnIfu;
      cnt_q          <= '0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      err            <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;

      if (lsu_req_ready) begin
        owner_q   <= OwnLsu;
        last_q    <= OwnLsu;
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
        cnt_q     <= '0;
      end else if (ifu_req_ready) begin
        owner_q   <= OwnIfu;
        last_q    <= OwnIfu;
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
        cnt_q     <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (finish) begin
        if (owner_q == OwnIfu) begin
          ifu_resp_valid <= 1'b1;
          ifu_rdata      <= resp_hit ? mem_rdata : '0;
        end else begin
          lsu_resp_valid <= 1'b1;
          lsu_rdata      <= (resp_hit && !mem_wen) ? mem_rdata : '0;
        end
      end

      if (tmo_hit && !resp_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter, built with TIMEOUT=8.
module tb_ysyx_22050612_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22050612_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // From the handshake cycle: REQ accepted at once, response one cycle later.
  // Returns in the cycle where the owner's resp_valid is visible.
  task automatic run_mem(input logic [63:0] rdata);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'h0;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = 64'h0;
    lsu_req_valid = 1'b0; lsu_addr = 64'h0; lsu_wen = 1'b0;
    lsu_wdata = 64'h0; lsu_wmask = 8'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'h0;

    // Reset state
    do_reset();
    #1;
    chk("rst_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("rst_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // IFU-only fetch at minimum latency
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
    #1;
    chk("ifu_ready_c0", 64'(ifu_req_ready), 64'd1);
    chk("lsu_ready_c0", 64'(lsu_req_ready), 64'd0);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    chk("ifu_memvalid_c1", 64'(mem_req_valid), 64'd1);
    chk("ifu_memaddr_c1", mem_addr, 64'h8000_0000);
    chk("ifu_memwen_c1", 64'(mem_wen), 64'd0);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h0010_0073;
    #1;
    chk("ifu_memvalid_c2", 64'(mem_req_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    #1;
    chk("ifu_resp_c3", 64'(ifu_resp_valid), 64'd1);
    chk("ifu_rdata_c3", ifu_rdata, 64'h0010_0073);
    chk("ifu_lsuresp_c3", 64'(lsu_resp_valid), 64'd0);
    tick();
    chk("ifu_resp_c4", 64'(ifu_resp_valid), 64'd0);

    // Ties after reset: LSU first, then alternate
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 64'h200;
    lsu_req_valid = 1'b1; lsu_addr = 64'h100; lsu_wen = 1'b0;
    #1;
    chk("tie1_lsu_ready", 64'(lsu_req_ready), 64'd1);
    chk("tie1_ifu_ready", 64'(ifu_req_ready), 64'd0);
    run_mem(64'hAAAA);
    #1;
    chk("tie1_lsu_resp", 64'(lsu_resp_valid), 64'd1);
    chk("tie1_lsu_rdata", lsu_rdata, 64'hAAAA);
    chk("tie1_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    chk("tie2_ifu_ready", 64'(ifu_req_ready), 64'd1);
    chk("tie2_lsu_ready", 64'(lsu_req_ready), 64'd0);
    run_mem(64'hBBBB);
    #1;
    chk("tie2_ifu_resp", 64'(ifu_resp_valid), 64'd1);
    chk("tie2_ifu_rdata", ifu_rdata, 64'hBBBB);
    chk("tie2_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    chk("tie3_lsu_ready", 64'(lsu_req_ready), 64'd1);
    run_mem(64'hCCCC);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1;
    chk("tie3_lsu_resp", 64'(lsu_resp_valid), 64'd1);
    chk("tie3_lsu_rdata", lsu_rdata, 64'hCCCC);

    // LSU store with memory stalling for three cycles
    tick();
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1004;
    lsu_wdata = 64'h1234_5678_0000_0000; lsu_wmask = 8'hF0;
    #1;
    chk("st_ready", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 64'hDEAD;
    lsu_wdata = 64'h0; lsu_wmask = 8'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      #1;
      chk("st_memvalid", 64'(mem_req_valid), 64'd1);
      chk("st_memaddr", mem_addr, 64'h8000_1004);
      chk("st_memwen", 64'(mem_wen), 64'd1);
      chk("st_memwdata", mem_wdata, 64'h1234_5678_0000_0000);
      chk("st_memwmask", 64'(mem_wmask), 64'hF0);
      tick();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hFFFF_0000_1111;
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    #1;
    chk("st_lsu_resp", 64'(lsu_resp_valid), 64'd1);
    chk("st_lsu_rdata", lsu_rdata, 64'd0);
    chk("st_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    tick();
    chk("st_lsu_resp_off", 64'(lsu_resp_valid), 64'd0);

    // Stray memory response in IDLE is ignored
    mem_resp_valid = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    tick();
    chk("idle_stray_ifu", 64'(ifu_resp_valid), 64'd0);
    chk("idle_stray_lsu", 64'(lsu_resp_valid), 64'd0);

    // Timeout: memory accepts but never answers
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0040;
    #1;
    chk("tmo_ready", 64'(ifu_req_ready), 64'd1);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rdata = 64'h5A5A;
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk("tmo_noresp", 64'(ifu_resp_valid), 64'd0);
      chk("tmo_noerr", 64'(err), 64'd0);
      tick();
      mem_req_ready = 1'b0;
    end
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_2000;
    #1;
    chk("tmo_resp_c9", 64'(ifu_resp_valid), 64'd1);
    chk("tmo_rdata_c9", ifu_rdata, 64'd0);
    chk("tmo_err_c9", 64'(err), 64'd1);
    chk("tmo_lsu_resp_c9", 64'(lsu_resp_valid), 64'd0);
    chk("tmo_next_ready", 64'(lsu_req_ready), 64'd1);
    run_mem(64'h55);
    lsu_req_valid = 1'b0;
    #1;
    chk("tmo_next_resp", 64'(lsu_resp_valid), 64'd1);
    chk("tmo_next_rdata", lsu_rdata, 64'h55);
    chk("tmo_err_sticky", 64'(err), 64'd1);

    // Reset while in WAIT abandons the transaction
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0080;
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; rst = 1'b1;
    #1;
    chk("rw_wait_state", 64'(mem_req_valid), 64'd0);
    tick();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h9999;
    #1;
    chk("rw_ifu_resp_c3", 64'(ifu_resp_valid), 64'd0);
    chk("rw_err_cleared", 64'(err), 64'd0);
    chk("rw_memaddr_cleared", mem_addr, 64'd0);
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    #1;
    chk("rw_late_ifu", 64'(ifu_resp_valid), 64'd0);
    chk("rw_late_lsu", 64'(lsu_resp_valid), 64'd0);
    ifu_req_valid = 1'b1;
    #1;
    chk("rw_idle_ready", 64'(ifu_req_ready), 64'd1);
    ifu_req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
